// File: rtl/rfsoc_ctrl_pkg.sv
// Shared definitions for the RFSoC channel control blocks: playback sequencer
// states and the default stream word width.
package rfsoc_ctrl_pkg;

    localparam int DEFAULT_DATA_W = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARMED = 2'd2,
        ST_PLAY  = 2'd3
    } wave_state_e;

endpackage

// File: rtl/wave_bram.sv
// Simple dual-port waveform RAM: one write port, one read port with a
// registered output (one cycle read latency), written to infer block RAM.
module wave_bram #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port; contents survive reset so no reset branch here.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/channel_wave_buffer.sv
// Per-DAC-channel waveform store: loads up to DEPTH words from the selector
// slice, then replays them to the DAC stage on trigger with optional looping.
module channel_wave_buffer
    import rfsoc_ctrl_pkg::*;
#(
    parameter int  DATA_W = DEFAULT_DATA_W,
    parameter int  DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [15:0]       loop_count,
    input  logic              trigger,
    input  logic              stop,
    output logic [DATA_W-1:0] m_dac_tdata,
    output logic              m_dac_tvalid,
    input  logic              m_dac_tready,
    output logic [1:0]        state_o,
    output logic              done,
    output logic              len_err
);

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

    function automatic logic len_valid(input logic [ADDR_W:0] len);
        return (len != {(ADDR_W+1){1'b0}}) && (len <= LEN_MAX);
    endfunction

    wave_state_e       state_r, state_nx_s;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [15:0]       loops_r, pass_r;
    logic              rd_done_r;
    logic              pend_r, pend_last_r;
    logic [DATA_W-1:0] out_data_r, skid_data_r;
    logic              out_valid_r, out_last_r, skid_valid_r, skid_last_r;
    logic              tready_r, done_r, len_err_r;

    logic              len_ok_s, new_load_s, wr_fire_s, wr_last_s;
    logic              trig_go_s, pop_s, flush_s, finish_s;
    logic              rd_en_s, rd_wrap_s, rd_last_s;
    logic [1:0]        fill_s;
    logic [ADDR_W-1:0] cur_ptr_s;
    logic [15:0]       cur_pass_s, cur_loops_s;
    logic [DATA_W-1:0] rd_data_s;

    wave_bram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_bram (
        .clk   (clk),
        .we    (wr_fire_s),
        .waddr (wr_ptr_r),
        .wdata (s_axis_tdata),
        .re    (rd_en_s),
        .raddr (cur_ptr_s),
        .rdata (rd_data_s)
    );

    // Handshake, credit and read-issue decode. The first read is issued in the
    // trigger cycle itself so the first beat appears two cycles later; the
    // credit counts a same-cycle pop so tready=1 sustains one beat per cycle.
    always_comb begin
        len_ok_s    = len_valid(load_len);
        new_load_s  = load_start && len_ok_s && (state_r != ST_PLAY);
        wr_fire_s   = (state_r == ST_LOAD) && s_axis_tvalid && tready_r;
        wr_last_s   = wr_fire_s && ({1'b0, wr_ptr_r} == (len_r - LEN_ONE));
        trig_go_s   = (state_r == ST_ARMED) && trigger && !load_start;
        pop_s       = out_valid_r && m_dac_tready;
        flush_s     = (state_r == ST_PLAY) && stop;
        finish_s    = (state_r == ST_PLAY) && !stop && pop_s && out_last_r;
        fill_s      = {1'b0, out_valid_r} + {1'b0, skid_valid_r} + {1'b0, pend_r} - {1'b0, pop_s};
        cur_ptr_s   = trig_go_s ? {ADDR_W{1'b0}} : rd_ptr_r;
        cur_pass_s  = trig_go_s ? 16'd1 : pass_r;
        cur_loops_s = trig_go_s ? loop_count : loops_r;
        rd_en_s     = trig_go_s ||
                      ((state_r == ST_PLAY) && !stop && !rd_done_r && (fill_s < 2'd2));
        rd_wrap_s   = ({1'b0, cur_ptr_s} == (len_r - LEN_ONE));
        rd_last_s   = rd_wrap_s && (cur_loops_s != 16'd0) && (cur_pass_s == cur_loops_s);
    end

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (new_load_s) state_nx_s = ST_LOAD;
                else            state_nx_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (new_load_s)     state_nx_s = ST_LOAD;
                else if (wr_last_s) state_nx_s = ST_ARMED;
                else                state_nx_s = ST_LOAD;
            end
            ST_ARMED: begin
                if (new_load_s)     state_nx_s = ST_LOAD;
                else if (trig_go_s) state_nx_s = ST_PLAY;
                else                state_nx_s = ST_ARMED;
            end
            ST_PLAY: begin
                if (stop || finish_s) state_nx_s = ST_ARMED;
                else                  state_nx_s = ST_PLAY;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            tready_r  <= 1'b0;
            done_r    <= 1'b0;
            len_err_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            tready_r  <= (state_nx_s == ST_LOAD);
            done_r    <= finish_s;
            len_err_r <= load_start && !len_ok_s && (state_r != ST_PLAY);
        end
    end

    // Load length and write pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_r    <= {(ADDR_W+1){1'b0}};
            wr_ptr_r <= {ADDR_W{1'b0}};
        end else if (new_load_s) begin
            len_r    <= load_len;
            wr_ptr_r <= {ADDR_W{1'b0}};
        end else if (wr_fire_s) begin
            wr_ptr_r <= wr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    // Read pointer, pass counter and in-flight read tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r    <= {ADDR_W{1'b0}};
            pass_r      <= 16'd0;
            loops_r     <= 16'd0;
            rd_done_r   <= 1'b0;
            pend_r      <= 1'b0;
            pend_last_r <= 1'b0;
        end else begin
            pend_r      <= rd_en_s;
            pend_last_r <= rd_en_s && rd_last_s;
            if (trig_go_s) begin
                loops_r <= loop_count;
            end
            if (rd_en_s) begin
                rd_ptr_r  <= rd_wrap_s ? {ADDR_W{1'b0}} : (cur_ptr_s + {{(ADDR_W-1){1'b0}}, 1'b1});
                pass_r    <= rd_wrap_s ? (cur_pass_s + 16'd1) : cur_pass_s;
                rd_done_r <= rd_last_s;
            end
        end
    end

    // Two-entry output buffer: head register drives the DAC, skid catches a
    // read that lands while the head is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_r   <= {DATA_W{1'b0}};
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            skid_data_r  <= {DATA_W{1'b0}};
            skid_valid_r <= 1'b0;
            skid_last_r  <= 1'b0;
        end else if (flush_s) begin
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_last_r  <= 1'b0;
        end else if (!out_valid_r || pop_s) begin
            if (skid_valid_r) begin
                out_data_r   <= skid_data_r;
                out_valid_r  <= 1'b1;
                out_last_r   <= skid_last_r;
                skid_valid_r <= pend_r;
                skid_last_r  <= pend_r && pend_last_r;
                if (pend_r) skid_data_r <= rd_data_s;
            end else begin
                out_valid_r <= pend_r;
                out_last_r  <= pend_r && pend_last_r;
                if (pend_r) out_data_r <= rd_data_s;
            end
        end else if (pend_r) begin
            skid_data_r  <= rd_data_s;
            skid_valid_r <= 1'b1;
            skid_last_r  <= pend_last_r;
        end
    end

    assign s_axis_tready = tready_r;
    assign m_dac_tdata   = out_data_r;
    assign m_dac_tvalid  = out_valid_r;
    assign state_o       = state_r;
    assign done          = done_r;
    assign len_err       = len_err_r;

endmodule

// File: tb/tb_channel_wave_buffer.sv
// Directed self-checking bench for channel_wave_buffer: length errors, load,
// single/multi-pass and endless playback, stop, load/trigger collision, reset.
module tb_channel_wave_buffer;

    localparam int DATA_W = 256;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic [15:0]       loop_count;
    logic              trigger;
    logic              stop;
    logic [DATA_W-1:0] m_dac_tdata;
    logic              m_dac_tvalid;
    logic              m_dac_tready;
    logic [1:0]        state_o;
    logic              done;
    logic              len_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [DATA_W-1:0] wave_a [4];

    channel_wave_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .load_start    (load_start),
        .load_len      (load_len),
        .loop_count    (loop_count),
        .trigger       (trigger),
        .stop          (stop),
        .m_dac_tdata   (m_dac_tdata),
        .m_dac_tvalid  (m_dac_tvalid),
        .m_dac_tready  (m_dac_tready),
        .state_o       (state_o),
        .done          (done),
        .len_err       (len_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bad_len(input logic [ADDR_W:0] len);
        load_len   = len;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("len_err_pulse", len_err, 1'b1);
        check("len_err_state", state_o, 2'd0);
        check("len_err_tready", s_axis_tready, 1'b0);
        step();
        check("len_err_clear", len_err, 1'b0);
    endtask

    task automatic do_load(input int n);
        load_len   = (ADDR_W+1)'(n);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("load_state", state_o, 2'd1);
        check("load_tready", s_axis_tready, 1'b1);
        for (int i = 0; i < n; i++) begin
            s_axis_tdata  = wave_a[i];
            s_axis_tvalid = 1'b1;
            step();
        end
        s_axis_tvalid = 1'b0;
        check("armed_state", state_o, 2'd2);
        check("armed_tready", s_axis_tready, 1'b0);
    endtask

    task automatic run_play(input logic [15:0] loops, input bit toggle, input int stop_at,
                            input int exp_beats, input int exp_done);
        int beats = 0;
        int dones = 0;
        int extra = 0;
        int cyc   = 0;
        bit stalled = 1'b0;
        logic [DATA_W-1:0] held = '0;
        loop_count   = loops;
        m_dac_tready = 1'b1;
        trigger      = 1'b1;
        step();
        trigger = 1'b0;
        check("lat1_tvalid", m_dac_tvalid, 1'b0);
        step();
        check("lat2_tvalid", m_dac_tvalid, 1'b1);
        while (cyc < 200 && beats < exp_beats) begin
            m_dac_tready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (stalled) begin
                check("stall_valid", m_dac_tvalid, 1'b1);
                check("stall_data", m_dac_tdata, held);
            end
            if (m_dac_tvalid && m_dac_tready) begin
                check("beat_data", m_dac_tdata, wave_a[beats % 4]);
                beats++;
                stalled = 1'b0;
            end else if (m_dac_tvalid) begin
                stalled = 1'b1;
                held    = m_dac_tdata;
            end else begin
                stalled = 1'b0;
            end
            step();
            cyc++;
            if (done) dones++;
        end
        if (stop_at > 0) begin
            m_dac_tready = 1'b0;
            stop = 1'b1;
            step();
            stop = 1'b0;
            check("stop_tvalid", m_dac_tvalid, 1'b0);
            if (done) dones++;
        end
        m_dac_tready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (m_dac_tvalid) extra++;
            step();
            if (done) dones++;
        end
        check("beat_count", beats, exp_beats);
        check("extra_beats", extra, 0);
        check("done_count", dones, exp_done);
        check("end_state", state_o, 2'd2);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            wave_a[i] = {8{32'hA0A0_0000 + 32'(i)}};
        end
        rst = 1'b1;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        load_start = 1'b0;
        load_len = '0;
        loop_count = 16'd0;
        trigger = 1'b0;
        stop = 1'b0;
        m_dac_tready = 1'b0;
        repeat (3) step();
        check("rst_state", state_o, 2'd0);
        check("rst_tready", s_axis_tready, 1'b0);
        check("rst_tvalid", m_dac_tvalid, 1'b0);
        check("rst_tdata", m_dac_tdata, '0);
        check("rst_done", done, 1'b0);
        check("rst_len_err", len_err, 1'b0);
        rst = 1'b0;
        step();

        bad_len(11'd0);
        bad_len(11'd1025);

        do_load(4);
        run_play(16'd1, 1'b0, 0, 4, 1);
        run_play(16'd3, 1'b1, 0, 12, 1);
        run_play(16'd0, 1'b0, 10, 10, 0);

        // Load request collides with trigger while armed: load wins.
        load_len   = 11'd4;
        load_start = 1'b1;
        trigger    = 1'b1;
        step();
        load_start = 1'b0;
        trigger    = 1'b0;
        check("collide_state", state_o, 2'd1);
        for (int k = 0; k < 4; k++) begin
            check("collide_no_play", m_dac_tvalid, 1'b0);
            step();
        end

        // Two words into the reload, then an asynchronous reset mid-cycle.
        for (int i = 0; i < 2; i++) begin
            s_axis_tdata  = wave_a[i];
            s_axis_tvalid = 1'b1;
            step();
        end
        s_axis_tvalid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("arst_state", state_o, 2'd0);
        check("arst_tready", s_axis_tready, 1'b0);
        check("arst_tvalid", m_dac_tvalid, 1'b0);
        check("arst_tdata", m_dac_tdata, '0);
        check("arst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();
        loop_count = 16'd1;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("post_rst_no_play", m_dac_tvalid, 1'b0);
            step();
        end
        check("post_rst_state", state_o, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
